uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UART transmit path (8-bit data, single-cycle enable, busy status) between N_REQ byte sources.
- Each source offers bytes over a valid/ready handshake. A per-byte "last" flag lets a source lock the channel for a multi-byte message, so messages from different sources never interleave.
- Sits between CPU/debug/monitor byte producers and the UART TX path, in the same clk_i domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_sched.sv | 136 +++++++++++++
 tb/tb_uart_tx_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler and its picker.
package uart_pkg;

  localparam int UART_BYTE_W      = 8;
  localparam int BUSY_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: the first requester at or after i_ptr wins,
// or only i_lockIdx is considered while the channel is locked.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_lock,
  input  logic [IDX_W-1:0] i_lockIdx,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    o_idx   = '0;
    o_found = 1'b0;
    cand    = '0;
    if (i_lock) begin
      o_idx   = i_lockIdx;
      o_found = i_req[i_lockIdx];
    end else begin
      // Walk from farthest to nearest so the candidate closest to the pointer is written last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
        if (i_req[cand]) begin
          o_idx   = cand;
          o_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX path between N_REQ byte sources.
// Define UART_TX_SCHED_PRIO_EN for fixed lowest-index-first priority instead.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                         clk_i,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ*UART_BYTE_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]             req_last_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [UART_BYTE_W-1:0]       uart_tx_data_o,
  output logic                         uart_tx_en_o,
  input  logic                         uart_busy_i,
  output logic [IDX_W-1:0]             grant_o,
  output logic                         locked_o,
  output logic                         err_o
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  sched_state_t           r_state, w_nextState;
  logic [N_REQ-1:0]       r_ready;
  logic [IDX_W-1:0]       r_pendIdx, r_grant, w_ptr, w_pickIdx;
  logic [UART_BYTE_W-1:0] r_data, w_pendData;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_locked, w_found, w_offering, w_accept, w_acceptLast;
  logic                   w_timeout, w_canPick;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  assign w_offering   = |r_ready;
  assign w_accept     = (r_state == IDLE) && w_offering && req_valid_i[r_pendIdx];
  assign w_acceptLast = w_accept && req_last_i[r_pendIdx];
  assign w_timeout    = (r_state == WAIT_BUSY) && !uart_busy_i && (r_cnt == CNT_W'(1));
  assign w_canPick    = (r_state == IDLE) && !w_offering && !uart_busy_i && w_found;

  uart_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req     (req_valid_i),
    .i_ptr     (w_ptr),
    .i_lock    (r_locked),
    .i_lockIdx (r_grant),
    .o_idx     (w_pickIdx),
    .o_found   (w_found)
  );

`ifdef UART_TX_SCHED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  // The pointer only moves past a source once its message ends or it times out.
  always_ff @(posedge clk_i) begin
    if (reset)             r_ptr <= '0;
    else if (w_timeout)    r_ptr <= nextIdx(r_grant);
    else if (w_acceptLast) r_ptr <= nextIdx(r_pendIdx);
  end

  assign w_ptr = r_ptr;
`endif

  always_comb begin
    w_pendData = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_pendIdx == IDX_W'(k)) w_pendData = req_data_i[k*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    uart_tx_en_o = 1'b0;
    err_o        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = ISSUE;
      end
      ISSUE: begin
        uart_tx_en_o = 1'b1;
        w_nextState  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        err_o = w_timeout;
        if (uart_busy_i)    w_nextState = WAIT_DONE;
        else if (w_timeout) w_nextState = IDLE;
      end
      WAIT_DONE: begin
        if (!uart_busy_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Ready is offered for one cycle after the pick; the byte moves only if valid is still high then.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_ready   <= '0;
      r_pendIdx <= '0;
      r_data    <= '0;
      r_grant   <= '0;
      r_locked  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_ready <= '0;
      if (w_canPick) begin
        r_ready   <= N_REQ'(1) << w_pickIdx;
        r_pendIdx <= w_pickIdx;
      end
      if (w_accept) begin
        r_data   <= w_pendData;
        r_grant  <= r_pendIdx;
        r_locked <= !req_last_i[r_pendIdx];
      end else if (w_timeout) begin
        r_locked <= 1'b0;
      end
      if (r_state == ISSUE)                          r_cnt <= CNT_W'(BUSY_TIMEOUT);
      else if (r_state == WAIT_BUSY && !uart_busy_i) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign req_ready_o    = r_ready;
  assign uart_tx_data_o = r_data;
  assign grant_o        = r_grant;
  assign locked_o       = r_locked;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queued byte sources and a TX busy model drive the DUT; a scoreboard
// holds the expected (byte, grant, lock) for every TX enable, plus directed reset/timeout/busy checks.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int N_REQ        = 4;
  localparam int IDX_W        = 2;
  localparam int BUSY_TIMEOUT = 4;
  localparam int FRAME        = 6;

  logic               clk_i       = 1'b0;
  logic               reset       = 1'b1;
  logic [N_REQ-1:0]   req_valid_i = '0;
  logic [N_REQ*8-1:0] req_data_i  = '0;
  logic [N_REQ-1:0]   req_last_i  = '0;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         uart_tx_data_o;
  logic               uart_tx_en_o;
  logic               uart_busy_i = 1'b0;
  logic [IDX_W-1:0]   grant_o;
  logic               locked_o;
  logic               err_o;

  typedef struct { logic [7:0] data; logic last; } srcByte_t;
  typedef struct { logic [7:0] data; logic [IDX_W-1:0] grant; logic locked; } expEntry_t;

  srcByte_t         srcQ[N_REQ][$];
  expEntry_t        expQ[$];
  logic [N_REQ-1:0] popFlag        = '0;
  bit               autoBusy       = 1'b1;
  bit               forceBusy      = 1'b0;
  int               busyLeft       = 0;
  int               checkCount     = 0;
  int               passCount      = 0;
  bit               readyNotOneHot = 1'b0;

  always #5 clk_i = ~clk_i;

  uart_tx_sched #(.N_REQ(N_REQ), .IDX_W(IDX_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk_i          (clk_i),
    .reset          (reset),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_tx_en_o   (uart_tx_en_o),
    .uart_busy_i    (uart_busy_i),
    .grant_o        (grant_o),
    .locked_o       (locked_o),
    .err_o          (err_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int src, input logic [7:0] data, input logic last);
    srcByte_t b;
    b.data = data;
    b.last = last;
    srcQ[src].push_back(b);
  endtask

  task automatic expectTx(input logic [7:0] data, input logic [IDX_W-1:0] grant, input logic locked);
    expEntry_t e;
    e.data   = data;
    e.grant  = grant;
    e.locked = locked;
    expQ.push_back(e);
  endtask

  function automatic bit srcPending();
    for (int k = 0; k < N_REQ; k++) if (srcQ[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".ready"},  req_ready_o,    0);
    checkOutput({tag, ".en"},     uart_tx_en_o,   0);
    checkOutput({tag, ".data"},   uart_tx_data_o, 0);
    checkOutput({tag, ".grant"},  grant_o,        0);
    checkOutput({tag, ".locked"}, locked_o,       0);
    checkOutput({tag, ".err"},    err_o,          0);
  endtask

  task automatic waitEnable(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (uart_tx_en_o === 1'b1) return;
    end
    checkOutput(name, uart_tx_en_o, 1);
  endtask

  task automatic waitReady(input string name, input logic [N_REQ-1:0] expected);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (req_ready_o !== '0) break;
    end
    checkOutput(name, req_ready_o, expected);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || srcPending()) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    repeat (FRAME + 4) @(negedge clk_i);
  endtask

  task automatic resetDut();
    @(negedge clk_i);
    reset = 1'b1;
    @(negedge clk_i);
    reset = 1'b0;
  endtask

  // TX path model: busy rises half a cycle after an enable and stays high for FRAME cycles.
  always @(negedge clk_i) begin
    if (uart_tx_en_o === 1'b1 && autoBusy) busyLeft = FRAME;
    else if (busyLeft > 0)                 busyLeft--;
    uart_busy_i = forceBusy || (busyLeft > 0);
  end

  // Sources present their queue head and drop it the half-cycle after a completed handshake.
  always @(negedge clk_i) begin
    for (int k = 0; k < N_REQ; k++) begin
      if (popFlag[k] && srcQ[k].size() > 0) srcQ[k].delete(0);
      popFlag[k] = req_valid_i[k] && (req_ready_o[k] === 1'b1);
      if (!popFlag[k]) begin
        req_valid_i[k]       = (srcQ[k].size() > 0);
        req_data_i[8*k +: 8] = (srcQ[k].size() > 0) ? srcQ[k][0].data : 8'h00;
        req_last_i[k]        = (srcQ[k].size() > 0) ? srcQ[k][0].last : 1'b0;
      end
    end
    if (!$onehot0(req_ready_o)) readyNotOneHot = 1'b1;
  end

  always @(negedge clk_i) begin
    if (uart_tx_en_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedEnable", uart_tx_en_o, 0);
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        checkOutput("txData",   uart_tx_data_o, e.data);
        checkOutput("txGrant",  grant_o,        e.grant);
        checkOutput("txLocked", locked_o,       e.locked);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] uart_tx_sched bench starting");
    repeat (2) @(negedge clk_i);
    checkResetValues("reset");
    reset = 1'b0;

    // Single source: ready pulse, enable exactly one cycle later.
    @(posedge clk_i); #1;
    applyStimulus(1, 8'h41, 1'b1);
    expectTx(8'h41, 1, 1'b0);
    waitReady("single.ready", 4'b0010);
    @(negedge clk_i);
    checkOutput("single.enAfterAccept", uart_tx_en_o, 1);
    checkOutput("single.readyDropped", req_ready_o, 0);
    repeat (3) @(negedge clk_i);
    checkOutput("single.noReadyWhileBusy", req_ready_o, 0);
    waitDrain("single.drain");

    // Round-robin from pointer 0 with sources 0, 2, 3 all requesting.
    resetDut();
    @(posedge clk_i); #1;
    applyStimulus(0, 8'hA0, 1'b1);
    applyStimulus(0, 8'hA1, 1'b1);
    applyStimulus(2, 8'hB2, 1'b1);
    applyStimulus(3, 8'hC3, 1'b1);
    expectTx(8'hA0, 0, 1'b0);
    expectTx(8'hB2, 2, 1'b0);
    expectTx(8'hC3, 3, 1'b0);
    expectTx(8'hA1, 0, 1'b0);
    waitDrain("rr.drain");
    checkOutput("rr.dataHeld", uart_tx_data_o, 8'hA1);
    checkOutput("rr.grantHeld", grant_o, 0);

    // Lock: source 2 owns the channel across a gap while source 0 keeps requesting.
    @(posedge clk_i); #1;
    applyStimulus(2, 8'h10, 1'b0);
    applyStimulus(0, 8'h55, 1'b1);
    expectTx(8'h10, 2, 1'b1);
    waitEnable("lock.firstEnable");
    repeat (FRAME + 10) @(negedge clk_i);
    checkOutput("lock.held", locked_o, 1);
    checkOutput("lock.othersWait", req_ready_o, 0);
    @(posedge clk_i); #1;
    applyStimulus(2, 8'h11, 1'b1);
    expectTx(8'h11, 2, 1'b0);
    expectTx(8'h55, 0, 1'b0);
    waitDrain("lock.drain");

    // Timeout: busy never rises, error pulses on the last WAIT_BUSY cycle and the lock is released.
    autoBusy = 1'b0;
    @(posedge clk_i); #1;
    applyStimulus(3, 8'h77, 1'b0);
    expectTx(8'h77, 3, 1'b1);
    waitEnable("timeout.enable");
    applyStimulus(1, 8'h22, 1'b1);
    expectTx(8'h22, 1, 1'b0);
    for (int i = 1; i < BUSY_TIMEOUT; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("timeout.errQuiet%0d", i), err_o, 0);
    end
    @(negedge clk_i);
    checkOutput("timeout.errPulse", err_o, 1);
    @(negedge clk_i);
    checkOutput("timeout.errOneCycle", err_o, 0);
    checkOutput("timeout.lockCleared", locked_o, 0);
    autoBusy = 1'b1;
    waitDrain("timeout.drain");

    // Busy at idle blocks acceptance; ready follows one cycle after busy falls.
    forceBusy = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    applyStimulus(0, 8'h5A, 1'b1);
    expectTx(8'h5A, 0, 1'b0);
    repeat (6) @(negedge clk_i);
    checkOutput("busyIdle.noReady", req_ready_o, 0);
    @(posedge clk_i); #1;
    forceBusy = 1'b0;
    @(negedge clk_i);
    checkOutput("busyIdle.stillNoReady", req_ready_o, 0);
    @(negedge clk_i);
    checkOutput("busyIdle.readyAfterBusy", req_ready_o, 4'b0001);
    waitDrain("busyIdle.drain");

    // Reset while waiting for the frame to finish; pointer must restart at 0.
    @(posedge clk_i); #1;
    applyStimulus(2, 8'h99, 1'b0);
    expectTx(8'h99, 2, 1'b1);
    waitEnable("rstMid.enable");
    repeat (2) @(negedge clk_i);
    reset = 1'b1;
    @(negedge clk_i);
    checkResetValues("rstMid");
    reset = 1'b0;
    @(posedge clk_i); #1;
    applyStimulus(3, 8'h33, 1'b1);
    applyStimulus(0, 8'h30, 1'b1);
    expectTx(8'h30, 0, 1'b0);
    expectTx(8'h33, 3, 1'b0);
    waitDrain("rstMid.drain");

    checkOutput("readyOneHot", readyNotOneHot, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
